noc_traffic_client: RTL
=======================

# noc_traffic_client

Parametrised traffic-generating endpoint for the torus NoC, attached to one router's local port. It injects a bounded stream of `N_PACKETS` packets under token-bucket regulation and holds each packet on a valid/ack handshake. Virtual channels are assigned round-robin and destinations come from an LFSR, never self-addressed. On the ejection side it counts delivered packets and flags misrouted ones, so the bench and system tests can use `done` and `err` as pass criteria.

## Interface
Parameters:
- `X_W`, 2: x coordinate width; `X_MAX = 1<<X_W`
- `Y_W`, 2: y coordinate width
- `VC_W`, 3: VC id width; channels are used 0..`(1<<VC_W)-1`
- `D_W`, 256: flit data width; must be ≥ `X_W+Y_W+SEQ_W`
- `X`, 0 / `Y`, 0: this client's own coordinates
- `N_PACKETS`, 128: packets to inject; `SEQ_W = $clog2(N_PACKETS+1)`
- `RATE`, 20: cycles per token refill (≥1)
- `SIGMA`, 3: bucket depth (≥1)

Ports:
- `clk` in 1: clock
- `rst_n` in 1: asynchronous, active-low reset
- `i_v` out 1: injection valid
- `i_ack` in 1: router accepted the current flit
- `i_vc` out `VC_W`: VC of the injected flit
- `i_x` out `X_W` / `i_y` out `Y_W`: destination
- `i_data` out `D_W`: payload
- `o_v` in 1: ejected flit valid
- `o_x` in `X_W` / `o_y` in `Y_W`: ejected flit's destination field
- `o_data` in `D_W`: ejected payload (not checked)
- `done` out 1: all `N_PACKETS` acked (sticky)
- `err` out 1: misrouted flit received (sticky)
- `rx_count` out 16: ejected flit count, saturates at 16'hFFFF

## Operation
- Two-state FSM: IDLE and WAIT_ACK.
  - In IDLE, when `tok_avail && sent < N_PACKETS`: consume a token, load the output registers, and go to WAIT_ACK.
  - In WAIT_ACK, on `i_ack`: increment `sent`. If another packet may issue in the same cycle (`tok_avail && sent+1 < N_PACKETS`), load it, consume a token, and stay in WAIT_ACK. Otherwise go to IDLE.
- `i_v` is 1 exactly in WAIT_ACK.
- Output fields are held stable while `i_v && !i_ack`.
- `i_ack` in IDLE is ignored.
- Sequence number `seq` counts packets issued, starting at 0.
  - `i_vc = seq[VC_W-1:0]`
  - `i_data = {zero-pad, X, Y, seq}`, with `seq` in the LSBs.
- Destination LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11; reset to 16'hACE1.
  - Advances once per issue.
  - `dx = lfsr[X_W-1:0]`, `dy = lfsr[X_W+Y_W-1:X_W]`.
  - If `(dx,dy)==(X,Y)`, `dx = (dx+1) mod X_MAX`.
- `done` rises the cycle after the ack of packet `N_PACKETS-1` and holds until reset.
- Receive side: each `o_v` cycle increments `rx_count` (saturating). If `o_x!=X || o_y!=Y`, `err` sets.

## Timing
- Reset values: `i_v=0`, `i_vc=0`, `i_x=0`, `i_y=0`, `i_data=0`, `done=0`, `err=0`, `rx_count=0`.
- Internal reset values: bucket full (`SIGMA`), refill counter 0, `seq=0`, `sent=0`.
- Latency: token available in IDLE at edge n → `i_v=1` after edge n.
- Back-to-back acks sustain one flit per cycle while tokens last.
- Token bucket:
  - The refill counter wraps every `RATE` cycles and adds 1 token, saturating at `SIGMA`.
  - Add and consume in the same cycle leave the count unchanged.
  - `tok_avail = (tokens != 0)`.
- After `done`, no further issue; the bucket keeps refilling.
- An `rst_n` assertion mid-handshake drops `i_v` immediately (asynchronous). After release, the client restarts from `seq 0`.
- `o_v` and injection are fully independent; both may act in the same cycle.

## Structure
- Package `noc_pkg`: `coord_t` (x/y struct), the LFSR seed and taps constant, and the FSM state enum.
- One sub-module, `token_bucket` (params `RATE`, `SIGMA`; ports `clk`, `rst_n`, `consume`, `token_available`). The remainder stays flat.

## Test plan
- Reset with `RATE=4`, `SIGMA=2`, `i_ack` tied high → `i_v` high on 2 consecutive cycles, then one pulse every 4 cycles.
- Hold `i_ack` low for 10 cycles while `i_v=1` → `i_vc`, `i_x`, `i_y`, `i_data` unchanged; `seq` advances only after the ack.
- `N_PACKETS=5`, immediate acks → exactly 5 handshakes, VCs 0,1,2,3,4, `done=1` one cycle after the 5th ack, `i_v` stays 0 afterwards.
- `X=1`, `Y=1`, force the LFSR to yield (1,1) → `i_x=2`, `i_y=1`. Over 1000 packets, no destination equals (1,1).
- Drive `o_v` 3 cycles with `(o_x,o_y)=(X,Y)`, then 1 cycle with `o_x=X+1` → `rx_count=4`, `err=1` from the 4th cycle on.
- Assert `rst_n=0` mid-WAIT_ACK, between clock edges → `i_v=0` immediately. After release, the first `i_data` seq is 0 and the LFSR output equals the post-reset sequence.

Source files
------------

// File: rtl/noc_pkg.sv
// ---------------------------------------------------------------------------
// noc_pkg
// Shared types and constants for the torus NoC traffic client.
//   coord_t     : (x, y) router coordinate, fields wide enough for any
//                 supported X_W / Y_W (up to 8 bits each)
//   LFSR_SEED   : reset value of the destination LFSR
//   LFSR_TAPS   : feedback mask for the right-shifting 16-bit Fibonacci
//                 LFSR (polynomial taps 16,14,13,11 -> state bits 0,2,3,5)
//   state_t     : injection FSM states
//   lfsr_step() : one LFSR advance
// ---------------------------------------------------------------------------
package noc_pkg;

    localparam int COORD_W = 8;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } coord_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_WAIT_ACK = 1'b1
    } state_t;

    // Shift right; the XOR of the tapped bits enters at the MSB.
    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {^(l & LFSR_TAPS), l[15:1]};
    endfunction

endpackage

// File: rtl/token_bucket.sv
// ---------------------------------------------------------------------------
// token_bucket
// Rate regulator: one token is added every RATE cycles, the bucket holds at
// most SIGMA tokens and starts full after reset.
//   clk             in  : clock
//   rst_n           in  : asynchronous active-low reset
//   consume         in  : take one token this cycle (only while available)
//   token_available out : bucket is non-empty
// ---------------------------------------------------------------------------
module token_bucket #(
    parameter int RATE  = 20,
    parameter int SIGMA = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic consume,
    output logic token_available
);

    localparam int CNT_W = (RATE > 1) ? $clog2(RATE) : 1;
    localparam int TOK_W = $clog2(SIGMA + 1);

    logic [CNT_W-1:0] r_cnt;
    logic [TOK_W-1:0] r_tokens;
    logic             w_refill;

    // The refill counter wraps on its last value; that wrap cycle is the refill.
    assign w_refill        = (int'(r_cnt) == RATE - 1);
    assign token_available = (r_tokens != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_tokens <= TOK_W'(SIGMA);
        end else begin
            r_cnt <= w_refill ? '0 : r_cnt + CNT_W'(1);
            // Refill and consume in the same cycle cancel out, even when full.
            if (w_refill && !consume) begin
                if (int'(r_tokens) < SIGMA) begin
                    r_tokens <= r_tokens + TOK_W'(1);
                end
            end else if (consume && !w_refill) begin
                r_tokens <= r_tokens - TOK_W'(1);
            end
        end
    end

endmodule

// File: rtl/noc_traffic_client.sv
// ---------------------------------------------------------------------------
// noc_traffic_client
// Traffic-generating endpoint on one router's local port. Injects N_PACKETS
// packets under token-bucket regulation, round-robin VCs, LFSR destinations
// (never itself); counts ejected flits and flags misrouted ones.
//
// Injection handshake: i_v/i_vc/i_x/i_y/i_data are registered. A flit is
// offered while i_v=1 and is transferred on a rising edge where i_v=1 and
// i_ack=1; until then every field is held stable. i_ack while i_v=0 has no
// effect. After a transfer the next flit may be offered in the very next
// cycle if a token is available.
//
//   clk, rst_n       : clock, asynchronous active-low reset
//   i_v, i_vc        : out, injection valid and VC (= seq low bits)
//   i_ack            : in, router accepted the current flit
//   i_x, i_y         : out, destination coordinates
//   i_data           : out, {zero pad, X, Y, seq}
//   o_v, o_x, o_y    : in, ejected flit valid and destination field
//   o_data           : in, ejected payload (ignored)
//   done             : out, all packets acknowledged (sticky)
//   err              : out, a flit for another node was ejected here (sticky)
//   rx_count         : out, ejected flit count, saturating
//   dbg_state        : out, current injection FSM state
// ---------------------------------------------------------------------------
module noc_traffic_client
    import noc_pkg::*;
#(
    parameter int X_W       = 2,
    parameter int Y_W       = 2,
    parameter int VC_W      = 3,
    parameter int D_W       = 256,
    parameter int X         = 0,
    parameter int Y         = 0,
    parameter int N_PACKETS = 128,
    parameter int RATE      = 20,
    parameter int SIGMA     = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             i_v,
    input  logic             i_ack,
    output logic [VC_W-1:0]  i_vc,
    output logic [X_W-1:0]   i_x,
    output logic [Y_W-1:0]   i_y,
    output logic [D_W-1:0]   i_data,
    input  logic             o_v,
    input  logic [X_W-1:0]   o_x,
    input  logic [Y_W-1:0]   o_y,
    input  logic [D_W-1:0]   o_data,
    output logic             done,
    output logic             err,
    output logic [15:0]      rx_count,
    output state_t           dbg_state
);

    localparam int     SEQ_W = $clog2(N_PACKETS + 1);
    localparam coord_t SELF  = {COORD_W'(X), COORD_W'(Y)};

    state_t           r_state;
    logic             r_v;
    logic [VC_W-1:0]  r_vc;
    logic [X_W-1:0]   r_x;
    logic [Y_W-1:0]   r_y;
    logic [D_W-1:0]   r_data;
    logic             r_done;
    logic             r_err;
    logic [15:0]      r_rx_count;
    logic [SEQ_W-1:0] r_seq;
    logic [SEQ_W-1:0] r_sent;
    logic [15:0]      r_lfsr;

    logic             w_tok_avail;
    logic             w_issue;
    logic             w_ack_hs;
    logic             w_last_ack;
    coord_t           w_dest;
    logic [D_W-1:0]   w_data;
    logic             w_unused_data;

    assign w_unused_data = ^o_data;

    token_bucket #(
        .RATE  (RATE),
        .SIGMA (SIGMA)
    ) u_bucket (
        .clk             (clk),
        .rst_n           (rst_n),
        .consume         (w_issue),
        .token_available (w_tok_avail)
    );

    assign w_ack_hs   = (r_state == ST_WAIT_ACK) && i_ack;
    assign w_last_ack = w_ack_hs && (int'(r_sent) + 1 == N_PACKETS);

    // Issue from IDLE, or chain the next packet onto the ack in WAIT_ACK.
    // In WAIT_ACK the packet being acked is not yet in r_sent, hence +1.
    always_comb begin
        w_issue = 1'b0;
        if (w_tok_avail) begin
            if (r_state == ST_IDLE) begin
                w_issue = (int'(r_sent) < N_PACKETS);
            end else begin
                w_issue = i_ack && (int'(r_sent) + 1 < N_PACKETS);
            end
        end
    end

    // Destination from the LFSR; a self-address is bumped to the next x.
    always_comb begin
        w_dest   = '0;
        w_dest.x = COORD_W'(r_lfsr[X_W-1:0]);
        w_dest.y = COORD_W'(r_lfsr[X_W+Y_W-1:X_W]);
        if (w_dest == SELF) begin
            w_dest.x = COORD_W'(X_W'(w_dest.x + COORD_W'(1)));
        end
    end

    always_comb begin
        w_data                    = '0;
        w_data[SEQ_W-1:0]         = r_seq;
        w_data[SEQ_W +: Y_W]      = Y_W'(Y);
        w_data[SEQ_W+Y_W +: X_W]  = X_W'(X);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_v     <= 1'b0;
            r_vc    <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_data  <= '0;
            r_done  <= 1'b0;
            r_seq   <= '0;
            r_sent  <= '0;
            r_lfsr  <= LFSR_SEED;
        end else begin
            if (w_ack_hs) begin
                r_sent <= r_sent + SEQ_W'(1);
            end
            if (w_last_ack) begin
                r_done <= 1'b1;
            end
            if (w_issue) begin
                r_state <= ST_WAIT_ACK;
                r_v     <= 1'b1;
                r_vc    <= VC_W'(r_seq);
                r_x     <= w_dest.x[X_W-1:0];
                r_y     <= w_dest.y[Y_W-1:0];
                r_data  <= w_data;
                r_seq   <= r_seq + SEQ_W'(1);
                r_lfsr  <= lfsr_step(r_lfsr);
            end else if (w_ack_hs) begin
                r_state <= ST_IDLE;
                r_v     <= 1'b0;
            end
        end
    end

    // Ejection side runs independently of injection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_count <= '0;
            r_err      <= 1'b0;
        end else if (o_v) begin
            if (r_rx_count != 16'hFFFF) begin
                r_rx_count <= r_rx_count + 16'd1;
            end
            if (o_x != X_W'(X) || o_y != Y_W'(Y)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign i_v       = r_v;
    assign i_vc      = r_vc;
    assign i_x       = r_x;
    assign i_y       = r_y;
    assign i_data    = r_data;
    assign done      = r_done;
    assign err       = r_err;
    assign rx_count  = r_rx_count;
    assign dbg_state = r_state;

endmodule
